// File: rtl/shiftreg_seq_if.sv
// Request channel into the shift-register sequencer: a parallel word plus
// shift direction and fill mode, moved over a valid/ready handshake.
interface shiftreg_seq_if #(
  parameter int N = 4
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         in_dir;
  logic [1:0]   in_fill;

  modport master (
    output in_valid,
    output in_data,
    output in_dir,
    output in_fill,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_dir,
    input  in_fill,
    output in_ready
  );
endinterface

// File: rtl/shiftreg_seq.sv
// Sequencer for an N-bit shift register: one parallel load followed by
// exactly N shifts, spaced GAP idle cycles apart, then a one-cycle done pulse.
module shiftreg_seq #(
  parameter int N   = 4,
  parameter int GAP = 1
) (
  input  logic             clk,
  input  logic             rst,
  shiftreg_seq_if.slave    req,
  input  logic             sout_left_i,
  input  logic             sout_right_i,
  output logic             step_o,
  output logic [1:0]       op_o,
  output logic [N-1:0]     d_o,
  output logic             shift_in_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int CW = $clog2(N + 1);
  localparam int GW = $clog2(GAP + 1);

  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

  localparam logic [1:0] OP_HOLD  = 2'b00;
  localparam logic [1:0] OP_LEFT  = 2'b01;
  localparam logic [1:0] OP_RIGHT = 2'b10;
  localparam logic [1:0] OP_LOAD  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_SHIFT,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    FILL_ZERO = 2'b00,
    FILL_ONE  = 2'b01,
    FILL_ROT  = 2'b10,
    FILL_RSVD = 2'b11
  } fill_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [GW-1:0] gap_q,   gap_d;
  logic [N-1:0]  data_q,  data_d;
  logic          dir_q,   dir_d;
  fill_t         fill_q,  fill_d;

  logic          ready;
  logic [1:0]    dir_op;

  assign dir_op = dir_q ? OP_RIGHT : OP_LEFT;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of the order the blocks are evaluated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      data_q  <= '0;
      dir_q   <= 1'b0;
      fill_q  <= FILL_ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      data_q  <= data_d;
      dir_q   <= dir_d;
      fill_q  <= fill_d;
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    data_d  = data_q;
    dir_d   = dir_q;
    fill_d  = fill_q;

    case (state_q)
      S_IDLE: begin
        if (req.in_valid) begin
          data_d  = req.in_data;
          dir_d   = req.in_dir;
          fill_d  = fill_t'(req.in_fill);
          cnt_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        gap_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_SHIFT;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      S_SHIFT: begin
        cnt_d   = cnt_q + CW'(1);
        gap_d   = '0;
        state_d = (cnt_q == CNT_LAST) ? S_DONE : S_WAIT;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore outputs straight from the state register, so an asynchronous reset
  // kills step and done in the same instant it forces IDLE.
  always_comb begin
    ready  = 1'b0;
    step_o = 1'b0;
    op_o   = OP_HOLD;
    busy_o = 1'b1;
    done_o = 1'b0;

    case (state_q)
      S_IDLE: begin
        ready  = 1'b1;
        busy_o = 1'b0;
      end
      S_LOAD: begin
        step_o = 1'b1;
        op_o   = OP_LOAD;
      end
      S_WAIT: begin
        op_o = (cnt_q == '0) ? OP_LOAD : dir_op;
      end
      S_SHIFT: begin
        step_o = 1'b1;
        op_o   = dir_op;
      end
      S_DONE: begin
        done_o = 1'b1;
      end
      default: begin
        busy_o = 1'b0;
      end
    endcase
  end

  always_comb begin
    shift_in_o = 1'b0;
    case (fill_q)
      FILL_ONE: shift_in_o = 1'b1;
      FILL_ROT: shift_in_o = dir_q ? sout_right_i : sout_left_i;
      default:  shift_in_o = 1'b0;
    endcase
  end

  assign req.in_ready = ready;
  assign d_o          = data_q;

endmodule

// File: tb/tb_shiftreg_seq.sv
// Bench for shiftreg_seq: two instances (N=4/GAP=1 and N=8/GAP=3) each driving
// a behavioural shift register, checked cycle by cycle against closed-form results.
module tb_shiftreg_seq;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  shiftreg_seq_if #(.N(4)) if4 ();
  shiftreg_seq_if #(.N(8)) if8 ();

  logic       step4, si4, busy4, done4;
  logic [1:0] op4;
  logic [3:0] d4;
  logic [3:0] q4 = '0;

  logic       step8, si8, busy8, done8;
  logic [1:0] op8;
  logic [7:0] d8;
  logic [7:0] q8 = '0;

  shiftreg_seq #(.N(4), .GAP(1)) dut4 (
    .clk          (clk),
    .rst          (rst),
    .req          (if4),
    .sout_left_i  (q4[3]),
    .sout_right_i (q4[0]),
    .step_o       (step4),
    .op_o         (op4),
    .d_o          (d4),
    .shift_in_o   (si4),
    .busy_o       (busy4),
    .done_o       (done4)
  );

  shiftreg_seq #(.N(8), .GAP(3)) dut8 (
    .clk          (clk),
    .rst          (rst),
    .req          (if8),
    .sout_left_i  (q8[7]),
    .sout_right_i (q8[0]),
    .step_o       (step8),
    .op_o         (op8),
    .d_o          (d8),
    .shift_in_o   (si8),
    .busy_o       (busy8),
    .done_o       (done8)
  );

  // Downstream shift registers, clocked only when the sequencer pulses step.
  always @(posedge clk) begin
    if (step4) begin
      case (op4)
        2'b11:   q4 <= d4;
        2'b01:   q4 <= {q4[2:0], si4};
        2'b10:   q4 <= {si4, q4[3:1]};
        default: q4 <= q4;
      endcase
    end
    if (step8) begin
      case (op8)
        2'b11:   q8 <= d8;
        2'b01:   q8 <= {q8[6:0], si8};
        2'b10:   q8 <= {si8, q8[7:1]};
        default: q8 <= q8;
      endcase
    end
  end

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Register contents after k shifts, from the fill rules in closed form.
  function automatic logic [7:0] exp_q(input int n, input logic [7:0] v, input logic dir,
                                       input logic [1:0] fill, input int k);
    int m = (1 << n) - 1;
    int x = int'(v);
    int r;
    case (fill)
      2'b01:   r = dir ? ((x >> k) | ((m << (n - k)) & m)) : (((x << k) | ((1 << k) - 1)) & m);
      2'b10:   r = dir ? (((x >> k) | (x << (n - k))) & m) : (((x << k) | (x >> (n - k))) & m);
      default: r = dir ? (x >> k) : ((x << k) & m);
    endcase
    return 8'(r);
  endfunction

  task automatic drive(input bit sel, input logic v, input logic [7:0] data,
                       input logic dir, input logic [1:0] fill);
    if (sel) begin
      if8.in_valid = v;
      if8.in_data  = data;
      if8.in_dir   = dir;
      if8.in_fill  = fill;
    end else begin
      if4.in_valid = v;
      if4.in_data  = data[3:0];
      if4.in_dir   = dir;
      if4.in_fill  = fill;
    end
  endtask

  task automatic sample(input bit sel, output logic st, output logic [1:0] op,
                        output logic [7:0] d, output logic dn, output logic bsy,
                        output logic rdy, output logic [7:0] q);
    st  = sel ? step8 : step4;
    op  = sel ? op8 : op4;
    d   = sel ? d8 : {4'b0, d4};
    dn  = sel ? done8 : done4;
    bsy = sel ? busy8 : busy4;
    rdy = sel ? if8.in_ready : if4.in_ready;
    q   = sel ? q8 : {4'b0, q4};
  endtask

  // Entered and left at a falling edge; the accept happens on the next rising
  // edge (cycle 0). Runs cycle by cycle up to 'stop' or the ready-return cycle.
  task automatic do_req(input bit sel, input logic [7:0] data, input logic dir,
                        input logic [1:0] fill, input bit hold, input int stop);
    int         n      = sel ? 8 : 4;
    int         per    = sel ? 4 : 2;
    int         done_c = 2 + n * per;
    int         last   = 3 + n * per;
    int         pulses = 0;
    logic [7:0] mask   = 8'((1 << n) - 1);
    logic [7:0] dat    = data & mask;
    string      nm     = $sformatf("n%0d_%02h_d%0d_f%0d", n, dat, dir, fill);
    logic       st, dn, bsy, rdy, exp_step;
    logic [1:0] op;
    logic [7:0] dd, q;

    sample(sel, st, op, dd, dn, bsy, rdy, q);
    check({nm, " ready@0"}, rdy, 1);
    drive(sel, 1'b1, dat, dir, fill);
    for (int c = 1; c <= last && c <= stop; c++) begin
      @(negedge clk);
      sample(sel, st, op, dd, dn, bsy, rdy, q);
      exp_step = (c <= 1 + n * per) && ((c - 1) % per == 0);
      if (st === 1'b1) pulses++;
      check($sformatf("%s c%0d step", nm, c), st, exp_step);
      if (exp_step) check($sformatf("%s c%0d op", nm, c), op, (c == 1) ? 3 : (dir ? 2 : 1));
      check($sformatf("%s c%0d d", nm, c), dd, dat);
      check($sformatf("%s c%0d done", nm, c), dn, c == done_c);
      check($sformatf("%s c%0d busy", nm, c), bsy, c <= done_c);
      check($sformatf("%s c%0d ready", nm, c), rdy, c == last);
      if (c >= 2 && c <= done_c && (c - 2) % per == 0)
        check($sformatf("%s c%0d q", nm, c), q, exp_q(n, dat, dir, fill, (c - 2) / per));
      if (c < last) drive(sel, hold, 8'($urandom), 1'($urandom), 2'($urandom));
    end
    if (stop >= last) check({nm, " pulses"}, pulses, n + 1);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, " step"}, step4, 0);
    check({tag, " busy"}, busy4, 0);
    check({tag, " done"}, done4, 0);
    check({tag, " ready"}, if4.in_ready, 1);
    check({tag, " op"}, op4, 0);
    check({tag, " d"}, d4, 0);
    check({tag, " shift_in"}, si4, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 1'b0, 2'b00);
    drive(1'b1, 1'b0, 8'h00, 1'b0, 2'b00);
    #12;
    reset_checks("por");
    check("por n8 ready", if8.in_ready, 1);
    check("por n8 step", step8, 0);
    check("por n8 d", d8, 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases from the N=4, GAP=1 scenarios.
    do_req(1'b0, 8'h0B, 1'b0, 2'b00, 1'b0, 100);
    do_req(1'b0, 8'h00, 1'b1, 2'b01, 1'b0, 100);
    do_req(1'b0, 8'h01, 1'b1, 2'b10, 1'b0, 100);
    do_req(1'b0, 8'h09, 1'b0, 2'b10, 1'b0, 100);
    do_req(1'b0, 8'h05, 1'b0, 2'b11, 1'b0, 100);

    // Valid held high across two words: second accept at the ready cycle.
    do_req(1'b0, 8'h0A, 1'b0, 2'b00, 1'b1, 100);
    do_req(1'b0, 8'h05, 1'b1, 2'b10, 1'b0, 100);

    // Abort after the second shift, during a wait cycle.
    @(negedge clk);
    do_req(1'b0, 8'h06, 1'b0, 2'b01, 1'b0, 6);
    #1 rst = 1'b1;
    #1 reset_checks("abort_c6");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("abort_c6 hold%0d done", i), done4, 0);
    end
    rst = 1'b0;
    do_req(1'b0, 8'h0C, 1'b1, 2'b00, 1'b0, 100);

    // Abort while the load pulse is high.
    do_req(1'b0, 8'h03, 1'b1, 2'b01, 1'b0, 1);
    #1 rst = 1'b1;
    #1 reset_checks("abort_c1");
    @(negedge clk);
    rst = 1'b0;

    // Wider register with a longer gap.
    do_req(1'b1, 8'hA5, 1'b0, 2'b00, 1'b0, 100);
    do_req(1'b1, 8'h81, 1'b1, 2'b10, 1'b0, 100);

    // Randomized requests on both instances, including the reserved fill code.
    for (int i = 0; i < 10; i++) begin
      do_req(1'($urandom), 8'($urandom), 1'($urandom), 2'($urandom), 1'b0, 100);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
